// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared stall-vector patterns and FSM encoding for the pipeline stall controller.
// Pure declarations, no logic or latency.
// Not applicable: no flow control in a package.
package pipeline_stall_ctrl_pkg;

    // stop_all bit map: [0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb
    localparam logic [5:0] STOP_FROM_EX = 6'b001111;  // hold PC..EX, let MEM/WB drain
    localparam logic [5:0] STOP_FROM_ID = 6'b000111;  // hold PC..ID, id_ex takes a bubble
    localparam logic [5:0] NO_STOP_ALL  = 6'b000000;

    typedef enum logic [1:0] {
        STALL_IDLE  = 2'd0,
        STALL_COUNT = 2'd1,
        STALL_DONE  = 2'd2
    } stall_state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Count visible one cycle after the increment request.
// No backpressure; holds at all-ones, clear takes priority over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear beats increment, increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Builds the pipeline stop_all vector from ID/EX requests and sequences multi-cycle EX ops.
// stop_all is combinational in the request cycle; done pulses N+1 cycles after start.
// Upstream stages are held while EX is busy; MEM/WB always keep draining.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = 6,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   id_stop_request,
    input  logic                   ex_stop_request,
    input  logic                   ex_multicycle_start,
    input  logic [COUNT_WIDTH-1:0] ex_multicycle_cycles,
    input  logic                   ex_multicycle_cancel,
    input  logic                   stall_count_clear,
    output logic [5:0]             stop_all,
    output logic                   ex_multicycle_done,
    output logic                   busy,
    output logic                   start_error,
    output logic [PERF_WIDTH-1:0]  stall_cycle_count
);

    stall_state_t           state_q, state_d;
    logic [COUNT_WIDTH-1:0] countdown_q, countdown_d;
    logic                   start_error_q, start_error_d;
    logic [COUNT_WIDTH-1:0] start_len;
    logic                   can_start;
    logic                   ex_stall;

    // A zero-length op still needs one countdown step to produce its result.
    assign start_len = (ex_multicycle_cycles == '0) ? COUNT_WIDTH'(1) : ex_multicycle_cycles;

    // DONE accepts a new start exactly like IDLE so ops can run back to back.
    assign can_start = (state_q == STALL_IDLE) || (state_q == STALL_DONE);

    // Next-state, countdown and sticky error logic.
    always_comb begin
        state_d       = state_q;
        countdown_d   = countdown_q;
        start_error_d = start_error_q;
        case (state_q)
            STALL_IDLE, STALL_DONE: begin
                state_d = STALL_IDLE;
                if (ex_multicycle_start && !ex_multicycle_cancel) begin
                    state_d     = STALL_COUNT;
                    countdown_d = start_len;
                end
            end
            STALL_COUNT: begin
                // A second start while counting is a protocol violation; the op continues.
                if (ex_multicycle_start) begin
                    start_error_d = 1'b1;
                end
                if (ex_multicycle_cancel) begin
                    state_d     = STALL_IDLE;
                    countdown_d = '0;
                end else if (countdown_q == COUNT_WIDTH'(1)) begin
                    state_d     = STALL_DONE;
                    countdown_d = '0;
                end else begin
                    countdown_d = countdown_q - COUNT_WIDTH'(1);
                end
            end
            default: begin
                state_d     = STALL_IDLE;
                countdown_d = '0;
            end
        endcase
    end

    // FSM state, countdown and error flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= STALL_IDLE;
            countdown_q   <= '0;
            start_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            countdown_q   <= countdown_d;
            start_error_q <= start_error_d;
        end
    end

    // The start cycle itself stalls, even if cancelled in the same cycle.
    assign ex_stall = ex_stop_request
                    || (can_start && ex_multicycle_start)
                    || (state_q == STALL_COUNT);

    // Stall vector mux: EX outranks ID; nothing is held while reset is asserted.
    always_comb begin
        stop_all = NO_STOP_ALL;
        if (reset) begin
            stop_all = NO_STOP_ALL;
        end else if (ex_stall) begin
            stop_all = STOP_FROM_EX;
        end else if (id_stop_request) begin
            stop_all = STOP_FROM_ID;
        end
    end

    assign ex_multicycle_done = (state_q == STALL_DONE);
    assign busy               = (state_q != STALL_IDLE);
    assign start_error        = start_error_q;

    sat_counter #(
        .WIDTH (PERF_WIDTH)
    ) u_stall_counter (
        .clock (clock),
        .reset (reset),
        .inc   (stop_all != NO_STOP_ALL),
        .clear (stall_count_clear),
        .count (stall_cycle_count)
    );

endmodule
